// File: rtl/riscv_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp with a bus register window and a level interrupt.
// Define MTIMER_PRESCALER_EN to add an 8-bit tick prescaler (CTRL[15:8]).
module riscv_mtimer #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sel_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          ack_o,
  output logic          t_intr_o
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] mtime_hi_shadow;
  logic        en;
  logic        ie;
  logic        tick;
  logic [7:0]  presc;
  logic [2:0]  word;
  logic        accept;
  logic        wr;
  logic        rd;
  logic        ctrl_wr;
  logic [31:0] rd_word;
  logic        unused_addr;

  assign word        = addr_i[4:2];
  assign unused_addr = ^addr_i[1:0];
  assign accept      = sel_i && !ack_o;
  assign wr          = accept && we_i;
  assign rd          = accept && !we_i;
  assign ctrl_wr     = wr && (word == 3'd4);

`ifdef MTIMER_PRESCALER_EN
  logic [7:0] presc_cnt;

  assign tick = en && (presc_cnt == presc);

  // A CTRL write restarts the prescale period so the first tick lands PRESC+1 clocks later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else if (ctrl_wr) begin
      presc     <= wdata_i[15:8];
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
    end
  end
`else
  assign presc = '0;
  assign tick  = en;
`endif

  always_comb begin
    rd_word = '0;
    case (word)
      3'd0:    rd_word = mtime[31:0];
      3'd1:    rd_word = mtime_hi_shadow;
      3'd2:    rd_word = mtimecmp[31:0];
      3'd3:    rd_word = mtimecmp[63:32];
      3'd4:    rd_word = {16'h0000, presc, 6'b000000, ie, en};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
      ack_o   <= 1'b0;
    end else begin
      ack_o   <= accept;
      rdata_o <= rd ? rd_word : '0;
    end
  end

  // A bus write to either mtime half takes priority over the tick in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime           <= '0;
      mtime_hi_shadow <= '0;
    end else begin
      if (wr && (word == 3'd0))
        mtime[31:0] <= wdata_i;
      else if (wr && (word == 3'd1))
        mtime[63:32] <= wdata_i;
      else if (tick)
        mtime <= mtime + 64'd1;
      if (rd && (word == 3'd0))
        mtime_hi_shadow <= mtime[63:32];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp <= '1;
      en       <= 1'b0;
      ie       <= 1'b0;
    end else begin
      if (wr && (word == 3'd2))
        mtimecmp[31:0] <= wdata_i;
      if (wr && (word == 3'd3))
        mtimecmp[63:32] <= wdata_i;
      if (ctrl_wr) begin
        en <= wdata_i[0];
        ie <= wdata_i[1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      t_intr_o <= 1'b0;
    else
      t_intr_o <= ie && (mtime >= mtimecmp);
  end

endmodule
